clkdiv_ctrl: RTL and testbench
==============================

# clkdiv_ctrl

Programmable, glitch-free clock-divider controller. Replaces fixed ripple divide-by-2/4/8 stages with a single synchronous period counter clocked by `clk`. Produces a registered divided clock and a period-start tick. Divide ratio changes and start/stop requests take effect only at period boundaries, so no runt pulse reaches downstream logic.

## Interface
- `CNT_W`, 8, width of divide ratio and period counter; max ratio 2^CNT_W-1
- `DEF_DIV`, 8, divide ratio loaded at reset; must be ≥2
- `clk` in 1: single clock, all state on its rising edge
- `rst_` in 1: reset, asynchronous and active-low
- `en` in 1: run request; level-sensitive
- `div_req` in 1: ratio-change request; held high until `div_ack`
- `div_val` in CNT_W: requested ratio N; stable while `div_req` high
- `div_ack` out 1: one-cycle pulse, request completed (applied or rejected)
- `div_err` out 1: one-cycle pulse with `div_ack` when `div_val` < 2
- `clk_out` out 1: registered divided clock
- `tick` out 1: one-cycle pulse on the first cycle of each `clk_out` period
- `running` out 1: high in RUN and PEND
- `cur_div` out CNT_W: ratio currently in effect

## Operation
- States: IDLE, RUN, PEND.
- IDLE: `clk_out`=0, counter held at 0. If `en`=1, go to RUN; next cycle `cnt`=0, `clk_out`=1, `tick`=1.
- RUN: `cnt` counts 0..N-1 and wraps. `clk_out`=1 while `cnt` < H, where H=(N+1)>>1, computed at CNT_W+1 bits. N=8 gives 4 high/4 low; N=5 gives 3/2; N=2 gives 1/1.
- Request handling:
  - In RUN, if `div_req`=1 and `div_ack`=0, latch `div_val` into `pend_div` and go to PEND.
  - In IDLE, a request is applied directly: `cur_div` updates and `div_ack` pulses on the next cycle.
  - If `en` rises in the same cycle as a request in IDLE, the first period uses the new ratio.
- PEND: keep counting with the old N. At the wrap (`cnt`=N-1), load `cur_div`←`pend_div` and pulse `div_ack`. The new period then starts with `tick` under the new N. Return to RUN.
- Invalid ratio (`div_val` < 2):
  - In IDLE, `div_ack` and `div_err` pulse on the next cycle.
  - In RUN, they pulse at the next wrap.
  - `cur_div` is unchanged in both cases.
- Requester drops `div_req` after `div_ack`. A request still high in the cycle after `div_ack` is treated as a new request. One outstanding request at most; `div_req` toggling while in PEND is ignored.
- Stop: `en`=0 in RUN or PEND finishes the current period, then goes to IDLE at the wrap.
  - A pending request is still applied or rejected at that wrap, with `div_ack` pulsed.
  - The final `clk_out` low phase is always complete.
- `en` back to 1 before the wrap cancels the stop with no disturbance.

## Timing
- All outputs are registered. No combinational input→output path.
- Reset values: `clk_out`=0, `tick`=0, `div_ack`=0, `div_err`=0, `running`=0, `cur_div`=DEF_DIV, state IDLE, `cnt`=0.
- Start latency: 1 cycle from `en` sampled high to `clk_out`/`tick` high.
- Change latency in RUN: `div_ack` is asserted in the first cycle of the new period, coincident with `tick`. Worst case N_old+1 cycles after the request is sampled.
- Async reset mid-period forces reset values immediately. The first period after release starts only via `en`.
- `tick` period equals `cur_div` cycles exactly. No period is ever shortened or lengthened mid-flight.

## Structure
- Package `clkdiv_pkg` holds:
  - state enum `clkdiv_state_t` {IDLE, RUN, PEND}
  - constant `DIV_MIN`=2
  - default `DEF_DIV`=8
- Sub-module `clkdiv_counter`: loadable period counter. Inputs: ratio, run, clear. Outputs: `cnt`, `wrap`, `hi` (`cnt` < H).
- The FSM, request latch and output registers stay in `clkdiv_ctrl`.

## Test plan
- Reset, `en`=0 → all outputs at reset values, `cur_div`=8. Assert `rst_` low mid-period → `clk_out`=0 and `running`=0 immediately.
- `en`=1, default N=8 → `clk_out` 4 high/4 low, `tick` every 8 cycles, first `tick` 1 cycle after `en` is sampled.
- In RUN with N=8, at `cnt`=2 request `div_val`=5 → 5 more cycles of the old period, then `div_ack`+`tick` together. Subsequent periods are 3 high/2 low; `cur_div`=5.
- Request `div_val`=1 in RUN → `div_ack`+`div_err` at the next wrap, `cur_div` unchanged, waveform undisturbed.
- Deassert `en` at `cnt`=1 with N=4 → period completes (2 high/2 low), then IDLE, `running`=0, `clk_out`=0.
- In IDLE, `div_req` with `div_val`=3 and `en`=1 in the same cycle → `div_ack` next cycle; first period is 2 high/1 low.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the programmable clock divider.
package clkdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } clkdiv_state_t;

  // Smallest ratio that still yields both a high and a low phase.
  localparam int unsigned DIV_MIN = 2;
  localparam int unsigned DEF_DIV = 8;

endpackage

// File: rtl/clkdiv_counter.sv
// Loadable period counter: counts 0..ratio-1 and wraps. The high-phase flag
// looks at the count about to be loaded, so the parent can register clk_out
// in step with the count it describes.
module clkdiv_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [CNT_W-1:0] ratio,
  input  logic             run,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             hi
);

  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W:0]   half;

  // One extra bit so ratio = 2^CNT_W-1 rounds up without overflow.
  assign half = ({1'b0, ratio} + (CNT_W+1)'(1)) >> 1;
  assign wrap = (cnt == ratio - CNT_W'(1));
  assign hi   = ({1'b0, cnt_nxt} < half);

  // Next count: clear dominates, otherwise advance and wrap while running.
  always_comb begin
    cnt_nxt = cnt;
    if (clear)
      cnt_nxt = '0;
    else if (run)
      cnt_nxt = wrap ? '0 : cnt + CNT_W'(1);
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)
      cnt <= '0;
    else
      cnt <= cnt_nxt;
  end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Glitch-free programmable clock divider controller. Ratio changes and
// start/stop only take effect at period boundaries.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | clk_out low, counter held at 0; ratio requests apply at once
//   RUN   | dividing with cur_div, no request outstanding
//   PEND  | dividing with old ratio, pend_div applied/rejected at wrap
module clkdiv_ctrl #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DEF_DIV = clkdiv_pkg::DEF_DIV
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             en,
  input  logic             div_req,
  input  logic [CNT_W-1:0] div_val,
  output logic             div_ack,
  output logic             div_err,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic [CNT_W-1:0] cur_div
);

  import clkdiv_pkg::*;

  localparam logic [CNT_W-1:0] DIV_MIN_W = CNT_W'(DIV_MIN);
  localparam logic [CNT_W-1:0] DEF_DIV_W = CNT_W'(DEF_DIV);

  clkdiv_state_t    state_q, state_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic [CNT_W-1:0] cur_div_d;
  logic             ack_d, err_d, tick_d, clk_out_d, running_d;
  logic             cnt_run, cnt_clear, start, wrap, hi;
  logic [CNT_W-1:0] cnt_unused;

  clkdiv_counter #(.CNT_W(CNT_W)) u_counter (
    .clk   (clk),
    .rst_  (rst_),
    .ratio (cur_div),
    .run   (cnt_run),
    .clear (cnt_clear),
    .cnt   (cnt_unused),
    .wrap  (wrap),
    .hi    (hi)
  );

  // Next-state, request handling and next values of the output registers.
  always_comb begin
    state_d    = state_q;
    pend_div_d = pend_div_q;
    cur_div_d  = cur_div;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    cnt_run    = 1'b0;
    cnt_clear  = 1'b0;
    start      = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_clear = 1'b1;
        // div_ack high means the requester has not yet dropped the old request.
        if (div_req && !div_ack) begin
          ack_d = 1'b1;
          if (div_val < DIV_MIN_W) err_d = 1'b1;
          else                     cur_div_d = div_val;
        end
        if (en) begin
          state_d = RUN;
          start   = 1'b1;
        end
      end
      RUN: begin
        cnt_run = 1'b1;
        // A stop at the wrap leaves any new request for IDLE to apply directly.
        if (wrap && !en) begin
          state_d = IDLE;
        end else if (div_req && !div_ack) begin
          pend_div_d = div_val;
          state_d    = PEND;
        end
      end
      PEND: begin
        cnt_run = 1'b1;
        if (wrap) begin
          ack_d = 1'b1;
          if (pend_div_q < DIV_MIN_W) err_d = 1'b1;
          else                        cur_div_d = pend_div_q;
          state_d = en ? RUN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d != IDLE);
    tick_d    = running_d && (start || wrap);
    clk_out_d = running_d && hi;
  end

  // State, pending ratio and all output registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= IDLE;
      pend_div_q <= DEF_DIV_W;
      cur_div    <= DEF_DIV_W;
      div_ack    <= 1'b0;
      div_err    <= 1'b0;
      tick       <= 1'b0;
      clk_out    <= 1'b0;
      running    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_div_q <= pend_div_d;
      cur_div    <= cur_div_d;
      div_ack    <= ack_d;
      div_err    <= err_d;
      tick       <= tick_d;
      clk_out    <= clk_out_d;
      running    <= running_d;
    end
  end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Directed bench for clkdiv_ctrl: inputs change on the falling edge, outputs
// are compared on the following falling edge.
module tb_clkdiv_ctrl;

  logic       clk = 1'b0;
  logic       rst_;
  logic       en;
  logic       div_req;
  logic [7:0] div_val;
  logic       div_ack, div_err, clk_out, tick, running;
  logic [7:0] cur_div;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clkdiv_ctrl #(.CNT_W(8), .DEF_DIV(8)) dut (
    .clk     (clk),
    .rst_    (rst_),
    .en      (en),
    .div_req (div_req),
    .div_val (div_val),
    .div_ack (div_ack),
    .div_err (div_err),
    .clk_out (clk_out),
    .tick    (tick),
    .running (running),
    .cur_div (cur_div)
  );

  // Compare {clk_out,tick,div_ack,div_err,running,cur_div} against exp.
  task automatic chk(input string tag, input logic [12:0] exp);
    logic [12:0] obs;
    obs = {clk_out, tick, div_ack, div_err, running, cur_div};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed co/tk/ak/er/rn=%05b div=%0d expected co/tk/ak/er/rn=%05b div=%0d",
             tag, obs[12:8], obs[7:0], exp[12:8], exp[7:0]);
    end
  endtask

  task automatic step_chk(input string tag, input logic co, input logic tk, input logic ak,
                          input logic er, input logic rn, input logic [7:0] dv);
    @(negedge clk);
    chk(tag, {co, tk, ak, er, rn, dv});
  endtask

  // Running period of ratio n, counts c0..c1, no ack: high while c < ceil(n/2).
  task automatic expect_run(input string tag, input int n, input int c0, input int c1);
    for (int c = c0; c <= c1; c++) begin
      @(negedge clk);
      chk($sformatf("%s_c%0d", tag, c), {(c < (n + 1) / 2), (c == 0), 2'b00, 1'b1, 8'(n)});
    end
  endtask

  initial begin
    rst_ = 1'b0; en = 1'b0; div_req = 1'b0; div_val = 8'd0;
    step_chk("rst0", 0, 0, 0, 0, 0, 8'd8);
    step_chk("rst1", 0, 0, 0, 0, 0, 8'd8);
    rst_ = 1'b1;
    step_chk("idle0", 0, 0, 0, 0, 0, 8'd8);

    // Default ratio 8: 4 high / 4 low, tick one cycle after en sampled.
    en = 1'b1;
    expect_run("n8a", 8, 0, 7);
    expect_run("n8b", 8, 0, 7);

    // Change to 5 requested at cnt=2: old period finishes, ack with tick.
    expect_run("chg_pre", 8, 0, 2);
    div_req = 1'b1; div_val = 8'd5;
    expect_run("chg_old", 8, 3, 7);
    step_chk("chg_ack", 1, 1, 1, 0, 1, 8'd5);
    div_req = 1'b0; div_val = 8'd0;
    expect_run("n5a", 5, 1, 4);
    expect_run("n5b", 5, 0, 4);

    // Invalid ratio 1 in RUN: rejected at the wrap, waveform undisturbed.
    expect_run("inv_pre", 5, 0, 0);
    div_req = 1'b1; div_val = 8'd1;
    expect_run("inv_run", 5, 1, 4);
    step_chk("inv_ack", 1, 1, 1, 1, 1, 8'd5);
    div_req = 1'b0;
    expect_run("n5c", 5, 1, 4);

    // Move to ratio 4.
    expect_run("n4_pre", 5, 0, 0);
    div_req = 1'b1; div_val = 8'd4;
    expect_run("n4_old", 5, 1, 4);
    step_chk("n4_ack", 1, 1, 1, 0, 1, 8'd4);
    div_req = 1'b0;

    // en dropped then restored before the wrap: no disturbance.
    en = 1'b0;
    expect_run("cancel", 4, 1, 1);
    en = 1'b1;
    expect_run("cancel", 4, 2, 3);

    // Stop at cnt=1: period completes 2 high / 2 low, then IDLE.
    expect_run("n4b", 4, 0, 1);
    en = 1'b0;
    expect_run("stop", 4, 2, 3);
    step_chk("stop_idle0", 0, 0, 0, 0, 0, 8'd4);
    step_chk("stop_idle1", 0, 0, 0, 0, 0, 8'd4);

    // Invalid ratio in IDLE: immediate ack+err, ratio kept.
    div_req = 1'b1; div_val = 8'd0;
    step_chk("idle_inv", 0, 0, 1, 1, 0, 8'd4);
    div_req = 1'b0;
    step_chk("idle_inv_done", 0, 0, 0, 0, 0, 8'd4);

    // Request 3 together with en in IDLE: first period already 2 high / 1 low.
    div_req = 1'b1; div_val = 8'd3; en = 1'b1;
    step_chk("go3", 1, 1, 1, 0, 1, 8'd3);
    div_req = 1'b0;
    expect_run("n3a", 3, 1, 2);
    expect_run("n3b", 3, 0, 2);

    // Asynchronous reset mid-period, away from any clock edge.
    expect_run("pre_rst", 3, 0, 0);
    #2 rst_ = 1'b0;
    #1 chk("async_rst", {5'b00000, 8'd8});
    en = 1'b0;
    @(negedge clk);
    rst_ = 1'b1;
    step_chk("post_rst0", 0, 0, 0, 0, 0, 8'd8);
    step_chk("post_rst1", 0, 0, 0, 0, 0, 8'd8);

    // Restart and switch to the minimum ratio 2: 1 high / 1 low.
    en = 1'b1;
    expect_run("restart", 8, 0, 0);
    div_req = 1'b1; div_val = 8'd2;
    expect_run("n2_old", 8, 1, 7);
    step_chk("n2_ack", 1, 1, 1, 0, 1, 8'd2);
    div_req = 1'b0;
    expect_run("n2a", 2, 1, 1);
    expect_run("n2b", 2, 0, 1);
    expect_run("n2c", 2, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
